// File: rtl/bfloat_pkg.sv
// Shared types for the bfloat16 dot-product sequencer: element type,
// zero constant, FSM state encoding and the signed-zero test.
package bfloat_pkg;

    typedef logic [15:0] bf16_t;

    localparam bf16_t BF16_ZERO = 16'h0000;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CLEAR = 3'd1,
        ST_ISSUE = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DONE  = 3'd4
    } state_e;

    // True for both +0 and -0; the sign bit is ignored
    function automatic logic is_bf16_zero(input bf16_t v);
        return (v[14:0] == 15'd0);
    endfunction

endpackage

// File: rtl/bfloat_dot_seq_if.sv
// Host + MAC signal bundle for bfloat_dot_seq.
// master: host / MAC side (drives writes, start, mac_result)
// slave : the sequencer itself
interface bfloat_dot_seq_if import bfloat_pkg::*; #(
    parameter int DEPTH = 16
) ();
    localparam int AW = $clog2(DEPTH);

    logic          wr_en;
    logic          wr_sel;
    logic [AW-1:0] wr_addr;
    bf16_t         wr_data;
    logic [AW:0]   len;
    logic          start;
    logic          busy;
    logic          done;
    logic          err;
    bf16_t         result;
    bf16_t         mac_a;
    bf16_t         mac_b;
    logic          mac_valid;
    logic          mac_clr;
    logic          mac_cntl;
    bf16_t         mac_result;

    modport master (
        output wr_en, wr_sel, wr_addr, wr_data, len, start, mac_result,
        input  busy, done, err, result, mac_a, mac_b, mac_valid, mac_clr, mac_cntl
    );

    modport slave (
        input  wr_en, wr_sel, wr_addr, wr_data, len, start, mac_result,
        output busy, done, err, result, mac_a, mac_b, mac_valid, mac_clr, mac_cntl
    );
endinterface

// File: rtl/bfloat_opbuf.sv
// Operand buffer: two DEPTH x 16 register arrays (vector A and B) with one
// write port and one combinational read port returning A[idx] and B[idx].
module bfloat_opbuf import bfloat_pkg::*; #(
    parameter  int DEPTH = 16,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          wr_en,
    input  logic          wr_sel,
    input  logic [AW-1:0] wr_addr,
    input  bf16_t         wr_data,
    input  logic [AW-1:0] rd_idx,
    output bf16_t         rd_a,
    output bf16_t         rd_b
);
    bf16_t mem_a [DEPTH];
    bf16_t mem_b [DEPTH];

    // Host write port; contents are intentionally not cleared by reset
    always_ff @(posedge clk) begin
        if (wr_en) begin
            if (wr_sel) mem_b[wr_addr] <= wr_data;
            else        mem_a[wr_addr] <= wr_data;
        end
    end

    assign rd_a = mem_a[rd_idx];
    assign rd_b = mem_b[rd_idx];
endmodule

// File: rtl/bfloat_dot_seq.sv
// bfloat_dot_seq: buffers two bfloat16 vectors, clears the MAC, streams the
// element pairs into it, waits out the MAC latency and captures the sum.
// Optional build macro BFLOAT_DOT_ZSKIP_EN: pairs with a +/-0 operand are
// not presented to the MAC (mac_valid low) while the cycle timing is kept.
module bfloat_dot_seq import bfloat_pkg::*; #(
    parameter  int DEPTH   = 16,
    parameter  int MAC_LAT = 3,
    localparam int AW      = $clog2(DEPTH)
) (
    input logic           clk,
    input logic           rst,
    bfloat_dot_seq_if.slave bus
);
    localparam int CW = (MAC_LAT > 1) ? $clog2(MAC_LAT) : 1;

    state_e        state;
    logic [AW-1:0] idx;
    logic [AW:0]   len_q;
    logic [CW-1:0] cnt;
    logic          done_r;
    logic          err_r;
    bf16_t         result_r;
    bf16_t         rd_a;
    bf16_t         rd_b;
    logic          pair_ok;
    logic          len_ok;

    assign len_ok = (bus.len != '0) && (bus.len <= (AW+1)'(DEPTH));

    bfloat_opbuf #(.DEPTH(DEPTH)) u_opbuf (
        .clk     (clk),
        .wr_en   (bus.wr_en && (state == ST_IDLE)),
        .wr_sel  (bus.wr_sel),
        .wr_addr (bus.wr_addr),
        .wr_data (bus.wr_data),
        .rd_idx  (idx),
        .rd_a    (rd_a),
        .rd_b    (rd_b)
    );

    // Sequencer FSM; result is captured on the edge that enters DONE so it is
    // valid during the done pulse
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            idx      <= '0;
            len_q    <= '0;
            cnt      <= '0;
            done_r   <= 1'b0;
            err_r    <= 1'b0;
            result_r <= BF16_ZERO;
        end else begin
            done_r <= 1'b0;
            err_r  <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (bus.start) begin
                        if (len_ok) begin
                            len_q <= bus.len;
                            idx   <= '0;
                            state <= ST_CLEAR;
                        end else begin
                            err_r <= 1'b1;
                        end
                    end
                end
                ST_CLEAR: state <= ST_ISSUE;
                ST_ISSUE: begin
                    if ({1'b0, idx} == len_q - 1'b1) begin
                        cnt   <= CW'(MAC_LAT - 1);
                        state <= ST_DRAIN;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                ST_DRAIN: begin
                    if (cnt == '0) begin
                        result_r <= bus.mac_result;
                        done_r   <= 1'b1;
                        state    <= ST_DONE;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Decide whether the current ISSUE pair is presented to the MAC
    always_comb begin
        pair_ok = (state == ST_ISSUE);
`ifdef BFLOAT_DOT_ZSKIP_EN
        if (is_bf16_zero(rd_a) || is_bf16_zero(rd_b)) pair_ok = 1'b0;
`else
`endif
    end

    assign bus.busy      = (state != ST_IDLE);
    assign bus.done      = done_r;
    assign bus.err       = err_r;
    assign bus.result    = result_r;
    assign bus.mac_valid = pair_ok;
    assign bus.mac_clr   = (state == ST_CLEAR);
    assign bus.mac_cntl  = 1'b0;
    assign bus.mac_a     = pair_ok ? rd_a : BF16_ZERO;
    assign bus.mac_b     = pair_ok ? rd_b : BF16_ZERO;
endmodule

// File: tb/tb_bfloat_dot_seq.sv
// Testbench for bfloat_dot_seq: acts as host and as a MAC_LAT-cycle MAC.
// Expected sums come from integer arithmetic on the written elements.
module tb_bfloat_dot_seq;
    localparam int DEPTH   = 16;
    localparam int MAC_LAT = 3;
    localparam int AW      = $clog2(DEPTH);
    localparam int NP      = MAC_LAT - 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    int          ia [DEPTH];
    int          ib [DEPTH];
    logic [15:0] ma [DEPTH];
    logic [15:0] mb [DEPTH];

    bfloat_dot_seq_if #(.DEPTH(DEPTH)) bus ();

    bfloat_dot_seq #(.DEPTH(DEPTH), .MAC_LAT(MAC_LAT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    function automatic real bf2r(input logic [15:0] b);
        logic [10:0] e;
        if (b[14:7] == 8'd0) return 0.0;
        e = {3'b000, b[14:7]} + 11'd896;
        return $bitstoreal({b[15], e, b[6:0], 45'd0});
    endfunction

    function automatic logic [15:0] r2bf(input real r);
        logic [63:0] d;
        logic [10:0] e;
        d = $realtobits(r);
        if (d[62:0] == 63'd0) return 16'h0000;
        e = d[62:52] - 11'd896;
        return {d[63], e[7:0], d[51:45]};
    endfunction

    function automatic logic [15:0] int2bf(input int v);
        int m;
        int p;
        logic [7:0] e;
        logic [6:0] f;
        if (v == 0) return 16'h0000;
        m = (v < 0) ? -v : v;
        p = 0;
        while ((m >> (p + 1)) != 0) p++;
        e = 8'(127 + p);
        if (p <= 7) f = 7'((m << (7 - p)) & 32'h7f);
        else        f = 7'((m >> (p - 7)) & 32'h7f);
        return {(v < 0), e, f};
    endfunction

    // MAC model: products travel NP cycles, then add into the accumulator
    real pp [NP];
    bit  pv [NP];
    real acc;
    always @(posedge clk) begin
        if (rst) begin
            acc <= 0.0;
            for (int i = 0; i < NP; i++) pv[i] <= 1'b0;
        end else begin
            if (bus.mac_clr)       acc <= 0.0;
            else if (pv[NP-1])     acc <= acc + pp[NP-1];
            pv[0] <= bus.mac_valid;
            pp[0] <= bf2r(bus.mac_a) * bf2r(bus.mac_b);
            for (int i = 1; i < NP; i++) begin
                pv[i] <= pv[i-1];
                pp[i] <= pp[i-1];
            end
        end
    end
    assign bus.mac_result = r2bf(acc);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wr(input bit sel, input int addr, input logic [15:0] bf, input int iv);
        @(negedge clk);
        bus.wr_en = 1'b1; bus.wr_sel = sel; bus.wr_addr = AW'(addr); bus.wr_data = bf;
        @(posedge clk);
        #1 bus.wr_en = 1'b0;
        if (sel) begin mb[addr] = bf; ib[addr] = iv; end
        else     begin ma[addr] = bf; ia[addr] = iv; end
    endtask

    task automatic run_dot(input int n, input logic [15:0] exp_res, input int exp_vld,
                           input logic [15:0] exp_fa, input logic [15:0] exp_fb,
                           input bit wr_sim, input int wa, input logic [15:0] wd,
                           input string tag);
        int cyc, done_cyc, clr_cyc, clr_cnt, busy_cnt, vld_cnt, done_cnt, zero_bad, cntl_bad;
        logic [15:0] res, fa, fb;
        cyc = 1; done_cyc = -1; clr_cyc = -1; clr_cnt = 0; busy_cnt = 0; vld_cnt = 0;
        done_cnt = 0; zero_bad = 0; cntl_bad = 0; res = 16'hdead; fa = 16'hdead; fb = 16'hdead;
        @(negedge clk);
        bus.len = (AW+1)'(n); bus.start = 1'b1;
        if (wr_sim) begin
            bus.wr_en = 1'b1; bus.wr_sel = 1'b0; bus.wr_addr = AW'(wa); bus.wr_data = wd;
        end
        @(negedge clk);
        bus.start = 1'b0; bus.wr_en = 1'b0;
        while (cyc <= 64) begin
            if (bus.busy) busy_cnt++;
            if (bus.mac_clr) begin clr_cnt++; if (clr_cyc < 0) clr_cyc = cyc; end
            if (bus.mac_cntl !== 1'b0) cntl_bad++;
            if (bus.mac_valid) begin
                if (vld_cnt == 0) begin fa = bus.mac_a; fb = bus.mac_b; end
                vld_cnt++;
            end else if (bus.mac_a !== 16'h0 || bus.mac_b !== 16'h0) zero_bad++;
            if (bus.done) begin done_cnt++; done_cyc = cyc; res = bus.result; end
            if (!bus.busy && done_cnt > 0) break;
            @(negedge clk);
            cyc++;
        end
        chk({tag, "_done_cyc"}, done_cyc, n + MAC_LAT + 2);
        chk({tag, "_done_cnt"}, done_cnt, 1);
        chk({tag, "_busy_cyc"}, busy_cnt, n + MAC_LAT + 2);
        chk({tag, "_clr_cyc"}, clr_cyc, 1);
        chk({tag, "_clr_cnt"}, clr_cnt, 1);
        chk({tag, "_vld_cnt"}, vld_cnt, exp_vld);
        chk({tag, "_idle_zero"}, zero_bad, 0);
        chk({tag, "_cntl"}, cntl_bad, 0);
        chk({tag, "_result"}, res, exp_res);
        chk({tag, "_result_held"}, bus.result, exp_res);
        if (exp_vld > 0) begin
            chk({tag, "_first_a"}, fa, exp_fa);
            chk({tag, "_first_b"}, fb, exp_fb);
        end
    endtask

    // Expectations from the element model: sum of integer products, pair
    // count and first presented pair (zero pairs excluded when skipping)
    task automatic ref_run(input int n, input bit wr_sim, input int wa, input int wv, input string tag);
        int sum, vld;
        logic [15:0] fa, fb;
        bit skip;
        if (wr_sim) begin ia[wa] = wv; ma[wa] = int2bf(wv); end
        sum = 0; vld = 0; fa = 16'h0; fb = 16'h0;
        for (int i = 0; i < n; i++) begin
            sum += ia[i] * ib[i];
`ifdef BFLOAT_DOT_ZSKIP_EN
            skip = (ma[i][14:0] == 15'd0) || (mb[i][14:0] == 15'd0);
`else
            skip = 1'b0;
`endif
            if (!skip) begin
                if (vld == 0) begin fa = ma[i]; fb = mb[i]; end
                vld++;
            end
        end
        run_dot(n, int2bf(sum), vld, fa, fb, wr_sim, wa, int2bf(wv), tag);
    endtask

    task automatic err_test(input int n, input string tag);
        @(negedge clk);
        bus.len = (AW+1)'(n); bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        chk({tag, "_err"}, bus.err, 1);
        chk({tag, "_busy"}, bus.busy, 0);
        chk({tag, "_vld"}, bus.mac_valid, 0);
        @(negedge clk);
        chk({tag, "_err_once"}, bus.err, 0);
        chk({tag, "_busy2"}, bus.busy, 0);
        chk({tag, "_vld2"}, bus.mac_valid, 0);
    endtask

    initial begin
        #5000000;
        $display("FAIL watchdog expired observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, done_seen;
        bus.wr_en = 0; bus.wr_sel = 0; bus.wr_addr = '0; bus.wr_data = '0;
        bus.len = '0; bus.start = 0;
        for (int i = 0; i < DEPTH; i++) begin ia[i] = 0; ib[i] = 0; ma[i] = 0; mb[i] = 0; end

        // Reset state
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk("rst_busy", bus.busy, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_err", bus.err, 0);
        chk("rst_vld", bus.mac_valid, 0);
        chk("rst_clr", bus.mac_clr, 0);
        chk("rst_cntl", bus.mac_cntl, 0);
        chk("rst_result", bus.result, 16'h0000);
        chk("rst_mac_a", bus.mac_a, 16'h0000);
        chk("rst_mac_b", bus.mac_b, 16'h0000);

        // Load A=[1,2], B=[2,3]
        wr(0, 0, 16'h3F80, 1); wr(0, 1, 16'h4000, 2);
        wr(1, 0, 16'h4000, 2); wr(1, 1, 16'h4040, 3);

        // Reset in ISSUE at idx=1 aborts the run
        @(negedge clk);
        bus.len = 5'd2; bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        chk("abort_clr", bus.mac_clr, 1);
        @(negedge clk);
        chk("abort_issue0", bus.mac_valid, 1);
        @(negedge clk);
        chk("abort_issue1_a", bus.mac_a, 16'h4000);
        rst = 1'b1;
        @(negedge clk);
        chk("abort_busy", bus.busy, 0);
        chk("abort_vld", bus.mac_valid, 0);
        chk("abort_done", bus.done, 0);
        chk("abort_result", bus.result, 16'h0000);
        rst = 1'b0;
        done_seen = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (bus.done || bus.busy) done_seen++;
        end
        chk("abort_quiet", done_seen, 0);
        chk("abort_result_kept", bus.result, 16'h0000);

        // Basic len=2 run: 1*2 + 2*3 = 8
        run_dot(2, 16'h4100, 2, 16'h3F80, 16'h4000, 0, 0, 16'h0, "len2");

        // Write during a run is ignored, rerun gives the same result
        fork
            run_dot(2, 16'h4100, 2, 16'h3F80, 16'h4000, 0, 0, 16'h0, "busy_wr");
            begin
                repeat (3) @(negedge clk);
                bus.wr_en = 1'b1; bus.wr_sel = 1'b0; bus.wr_addr = '0; bus.wr_data = 16'h4040;
                @(negedge clk);
                bus.wr_en = 1'b0;
            end
        join
        run_dot(2, 16'h4100, 2, 16'h3F80, 16'h4000, 0, 0, 16'h0, "rerun");

        // Write A[1]=4 together with start: 1*2 + 4*3 = 14
        ref_run(2, 1, 1, 4, "wr_start");

        // len=1: -2 * 1 = -2
        wr(0, 0, 16'hC000, -2); wr(1, 0, 16'h3F80, 1);
        run_dot(1, 16'hC000, 1, 16'hC000, 16'h3F80, 0, 0, 16'h0, "len1");

        // Illegal lengths
        err_test(0, "len0");
        err_test(DEPTH + 1, "len17");

        // Zero operand: A=[0,2], B=[1,2] -> 4.0, then with -0
        wr(0, 0, 16'h0000, 0); wr(0, 1, 16'h4000, 2);
        wr(1, 0, 16'h3F80, 1); wr(1, 1, 16'h4000, 2);
        ref_run(2, 0, 0, 0, "zero");
        chk("zero_lit", bus.result, 16'h4080);
        wr(0, 0, 16'h8000, 0);
        ref_run(2, 0, 0, 0, "negzero");

        // Randomized runs, small integer operands keep every sum exact
        for (int t = 0; t < 8; t++) begin
            for (int i = 0; i < DEPTH; i++) begin
                int va, vb;
                va = int'($urandom_range(8)) - 4;
                vb = int'($urandom_range(8)) - 4;
                wr(0, i, int2bf(va), va);
                wr(1, i, int2bf(vb), vb);
            end
            n = (t == 0) ? DEPTH : int'($urandom_range(DEPTH - 1, 1));
            ref_run(n, 0, 0, 0, $sformatf("rand%0d", t));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
